// File: rtl/trace_pkg.sv
// Shared types for the writeback-trace UART transmitter: trace entry layout,
// transmitter FSM states and the frame byte selector.
package trace_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // 'rd' holds WBReg (the name 'reg' is reserved in SystemVerilog)
    typedef struct packed {
        logic        br;
        logic [3:0]  rd;
        logic [23:0] data;
    } trace_entry_t;

    function automatic logic [7:0] frame_byte(input trace_entry_t e, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = {e.br, 3'b000, e.rd};
            3'd2:    b = e.data[23:16];
            3'd3:    b = e.data[15:8];
            default: b = e.data[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Trace entry FIFO with combinational read-out so the transmitter can pop an
// entry in the cycle right after it was written. Push is accepted when full if a pop occurs.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  trace_entry_t             din,
    input  logic                     pop,
    output trace_entry_t             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    trace_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/wb_trace_uart_tx.sv
// Writeback trace transmitter: buffers retired register writebacks and sends each
// as a 5-byte 8N1 UART frame (sync, {br,reg}, data[23:16], data[15:8], data[7:0]).
module wb_trace_uart_tx
    import trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    input  logic [3:0]               wb_reg,
    input  logic [23:0]              wb_data,
    input  logic                     branch_taken,
    output logic                     tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int             BW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_BYTE = 3'(FRAME_BYTES - 1);

    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [7:0]    shift_q, shift_d;
    trace_entry_t  entry_q, entry_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;

    trace_entry_t  wb_entry, fifo_dout;
    logic          fifo_full, fifo_empty, pop, baud_tick;

    assign wb_entry = {branch_taken, wb_reg, wb_data};

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (wb_valid),
        .din   (wb_entry),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign baud_tick  = (baud_q == BAUD_LAST);
    assign overflow_d = overflow_q | (wb_valid & fifo_full & ~pop);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        entry_d    = entry_q;
        pop        = 1'b0;
        case (state_q)
            START: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        shift_d    = frame_byte(entry_q, byte_idx_q + 3'd1);
                        state_d    = START;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    entry_d    = fifo_dout;
                    byte_idx_d = '0;
                    shift_d    = SYNC_BYTE;
                    state_d    = START;
                end
            end
        endcase

        // tx follows the next state so the line changes on the same edge as the FSM
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            entry_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            entry_q    <= entry_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_wb_trace_uart_tx.sv
// Bench for wb_trace_uart_tx: a UART receiver monitor decodes tx and pops expected
// bytes from a scoreboard queue filled by the stimulus process.
module tb_wb_trace_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_reg = '0;
    logic [23:0] wb_data = '0;
    logic        branch_taken = 1'b0;
    logic        tx, busy, overflow;
    logic [3:0]  fifo_level;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    wb_trace_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .branch_taken (branch_taken),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic expect_frame(input logic br, input logic [3:0] r, input logic [23:0] d);
        exp_q.push_back(8'hA5);
        exp_q.push_back({br, 3'b000, r});
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
    endtask

    task automatic wait_idle(input int limit);
        bit done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy && fifo_level == 4'd0) begin
                done = 1'b1;
                break;
            end
        end
        check("idle_reached", {31'd0, done}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    // UART receiver: samples on the falling clock edge, one sample per bit period
    initial begin : uart_rx
        logic [7:0] rx_byte;
        logic [7:0] exp_byte;
        bit aborted;
        forever begin
            @(negedge clk);
            if (reset && tx === 1'b0) begin
                aborted = 1'b0;
                rx_byte = '0;
                for (int i = 0; i < 9 && !aborted; i++) begin
                    for (int k = 0; k < CPB; k++) begin
                        @(negedge clk);
                        if (!reset) aborted = 1'b1;
                    end
                    if (!aborted && i < 8) rx_byte[i] = tx;
                end
                if (!aborted) begin
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rx_byte: got %02h expected none (queue empty)", rx_byte);
                    end else begin
                        exp_byte = exp_q.pop_front();
                        check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_byte});
                    end
                end else begin
                    $display("rx: byte abandoned by reset");
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cnt;
        int peak;
        int zeros;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        repeat (5) @(negedge clk);

        // 1: reset mid-idle
        #2 reset = 1'b0;
        #1;
        check("t1_tx", {31'd0, tx}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_overflow", {31'd0, overflow}, 32'd0);
        check("t1_level", {28'd0, fifo_level}, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);

        // 2: single event, latency and busy duration
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'hAB);
        wb_valid = 1'b1; branch_taken = 1'b0; wb_reg = 4'h3; wb_data = 24'h0012AB;
        @(negedge clk);
        wb_valid = 1'b0;
        check("t2_tx_at_capture", {31'd0, tx}, 32'd1);
        check("t2_level_at_capture", {28'd0, fifo_level}, 32'd1);
        @(negedge clk);
        check("t2_tx_start", {31'd0, tx}, 32'd0);
        check("t2_level_after_pop", {28'd0, fifo_level}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy) break;
            cnt++;
            @(negedge clk);
        end
        check("t2_busy_cycles", cnt, 32'd200);
        wait_idle(50);

        // 3: all-ones data with branch taken
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h8F);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        @(negedge clk);
        wb_valid = 1'b1; branch_taken = 1'b1; wb_reg = 4'hF; wb_data = 24'hFFFFFF;
        @(negedge clk);
        wb_valid = 1'b0;
        wait_idle(400);

        // 4: 10 back-to-back events from empty; 10th is dropped
        for (int i = 0; i < 9; i++) begin
            expect_frame(i[0], 4'(i), {8'hC0 + 8'(i), 8'h3C, 8'(i * 17)});
        end
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            if (i == 9) check("t4_overflow_before_10th", {31'd0, overflow}, 32'd0);
            wb_valid = 1'b1; branch_taken = i[0]; wb_reg = 4'(i);
            wb_data = {8'hC0 + 8'(i), 8'h3C, 8'(i * 17)};
        end
        @(negedge clk);
        wb_valid = 1'b0;
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
        check("t4_overflow_after_10th", {31'd0, overflow}, 32'd1);
        check("t4_level_peak", peak, 32'd8);
        wait_idle(9 * 210 + 50);
        check("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

        // 5: two events one cycle apart, one idle cycle between frames
        expect_frame(1'b0, 4'h1, 24'h111111);
        expect_frame(1'b1, 4'h2, 24'h2A2A2A);
        @(negedge clk);
        wb_valid = 1'b1; branch_taken = 1'b0; wb_reg = 4'h1; wb_data = 24'h111111;
        @(negedge clk);
        branch_taken = 1'b1; wb_reg = 4'h2; wb_data = 24'h2A2A2A;
        @(negedge clk);
        wb_valid = 1'b0;
        check("t5_first_start", {31'd0, tx}, 32'd0);
        repeat (199) @(negedge clk);
        check("t5_last_stop", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("t5_gap_tx", {31'd0, tx}, 32'd1);
        check("t5_gap_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("t5_second_start", {31'd0, tx}, 32'd0);
        check("t5_second_busy", {31'd0, busy}, 32'd1);
        wait_idle(400);

        // 6: reset during byte 2 data bits with 3 entries queued
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h05);
        @(negedge clk);
        wb_valid = 1'b1; branch_taken = 1'b0; wb_reg = 4'h5; wb_data = 24'h007E81;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wb_reg = 4'(6 + i); wb_data = 24'h123456;
        end
        @(negedge clk);
        wb_valid = 1'b0;
        check("t6_queued", {28'd0, fifo_level}, 32'd3);
        repeat (92) @(negedge clk);
        check("t6_tx_low_before_reset", {31'd0, tx}, 32'd0);
        #2 reset = 1'b0;
        #1;
        check("t6_tx_async", {31'd0, tx}, 32'd1);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_level", {28'd0, fifo_level}, 32'd0);
        check("t6_overflow", {31'd0, overflow}, 32'd0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        zeros = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) zeros++;
        end
        check("t6_no_frames", zeros, 32'd0);
        check("t6_level_after", {28'd0, fifo_level}, 32'd0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
